// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, constants and the fetch packet type
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_pkt_t;
endpackage

// File: rtl/ifq2.sv
// ifq2: 2-entry fetch response FIFO; head is a register so decode sees registered outputs
module ifq2 import cpu_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic [1:0] count,
    output fetch_pkt_t head
);
    localparam fetch_pkt_t EMPTY = '{instr: NOP_INSTR, pc: 32'h0};
    fetch_pkt_t tail;
    logic [1:0] wp;
    assign wp = count - {1'b0, pop};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count <= 2'd0;
            head  <= EMPTY;
            tail  <= EMPTY;
        end else begin
            count <= flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            head  <= (push && wp == 2'd0) ? din : (pop ? tail : head);
            tail  <= (push && wp == 2'd1) ? din : tail;
        end
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && !flush && count == 2'd2));
    assert property (@(posedge clk) disable iff (reset) !(pop && count == 2'd0));
endmodule

// File: rtl/ifetch32.sv
// ifetch32: PC, RAM address issue and in-flight tracking feeding ifq2.
// Define IFETCH_PERF_EN to add perf_fetched/perf_flushes counters.
module ifetch32 import cpu_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] iin,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushes
`endif
);
    logic [31:0] pc, tag;
    logic        inflight, pop, issue, push;
    logic [1:0]  count;
    fetch_pkt_t  head;
    assign pop       = out_valid & out_ready;
    // Queue slots plus the outstanding read never exceed the depth, so pushes cannot overflow
    assign issue     = ((32'(count) + 32'(inflight) < QDEPTH) | pop) & ~br_take;
    assign push      = inflight & ~br_take;
    assign iaddr     = pc;
    assign out_valid = count != 2'd0;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc       <= RESET_VECTOR;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            pc       <= br_take ? (br_target & ~32'd3) : (issue ? pc + 32'd4 : pc);
            tag      <= issue ? pc : tag;
            inflight <= issue;
        end
    ifq2 u_q (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (br_take),
        .din   ('{instr: iin, pc: tag}),
        .count (count),
        .head  (head)
    );
`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            perf_fetched <= perf_fetched + {31'b0, pop};
            perf_flushes <= perf_flushes + {15'b0, br_take};
        end
`endif
endmodule

// File: tb/tb_ifetch32.sv
// tb_ifetch32: scoreboard bench for ifetch32; RAM word at address 4i holds i
module tb_ifetch32;
    import cpu_pkg::*;
    logic        clk = 0, reset = 1, br_take = 0, out_ready = 0;
    logic [31:0] iaddr, iin, out_instr, out_pc, br_target = 0;
    logic        out_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushes;
`endif
    int          tests = 0, fails = 0, popped = 0;
    logic        sb_on = 0;
    logic [31:0] exp_q[$];

    ifetch32 dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .iin(iin),
        .br_take(br_take), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) iin <= iaddr >> 2;

    always @(negedge clk) begin : sb
        logic [31:0] e;
        if (sb_on && out_valid && out_ready) begin
            popped++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got pc=%h instr=%h, expected no output", out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== (e >> 2)) begin
                    fails++;
                    $display("FAIL sb_pair: got pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, e, e >> 2);
                end
            end
        end
    end

    task automatic load_seq(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 40; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic startup_checks;
        @(negedge clk);
        tests++; if (iaddr !== 32'h0) begin fails++; $display("FAIL c0_iaddr: got %h expected 0", iaddr); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL c0_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL c1_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL c2_valid: got %b expected 1", out_valid); end
        tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL c2_pc: got %h expected 0", out_pc); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        tests++; if (iaddr !== 32'h0) begin fails++; $display("FAIL rst_iaddr: got %h expected 0", iaddr); end
        tests++; if (out_instr !== NOP_INSTR) begin fails++; $display("FAIL rst_instr: got %h expected %h", out_instr, NOP_INSTR); end
        tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
        @(posedge clk); #1;
        reset = 0; out_ready = 1; load_seq(32'h0); sb_on = 1;
        startup_checks();
    endtask

    task automatic test_free_run;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL run_valid: got %b expected 1", out_valid); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        held = 0;
        @(posedge clk); #1 out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) held = iaddr;
            if (i == 4) begin
                tests++; if (dut.u_q.count !== 2'd2) begin fails++; $display("FAIL bp_count: got %0d expected 2", dut.u_q.count); end
                tests++; if (iaddr !== held) begin fails++; $display("FAIL bp_iaddr: got %h expected %h", iaddr, held); end
            end
        end
        @(posedge clk); #1 out_ready = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_branch;
        @(posedge clk); #1 out_ready = 0;
        repeat (3) @(negedge clk);
        tests++; if (dut.u_q.count !== 2'd2) begin fails++; $display("FAIL br_full: got %0d expected 2", dut.u_q.count); end
        @(posedge clk); #1 br_take = 1; br_target = 32'h103;
        @(posedge clk); #1 br_take = 0; out_ready = 1; load_seq(32'h100);
        @(negedge clk);
        tests++; if (iaddr !== 32'h100) begin fails++; $display("FAIL br_iaddr: got %h expected 100", iaddr); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL br_n1_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL br_n2_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin fails++; $display("FAIL br_n3: got valid=%b pc=%h expected 1/100", out_valid, out_pc); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_branch_pop(input logic [31:0] tgt, input bit wrap);
        int n0;
        @(posedge clk); #1 br_take = 1; br_target = tgt; n0 = popped;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_pop_valid: got %b expected 1", out_valid); end
        @(posedge clk); #1 br_take = 0; load_seq(tgt);
        @(negedge clk);
        tests++; if (popped !== n0 + 1) begin fails++; $display("FAIL bp_pop_once: got %0d pops expected %0d", popped - n0, 1); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_n1_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_n2_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_pc !== tgt) begin fails++; $display("FAIL bp_n3: got valid=%b pc=%h expected 1/%h", out_valid, out_pc, tgt); end
        if (wrap) begin
            @(negedge clk);
            tests++; if (out_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_1: got %h expected fffffffc", out_pc); end
            @(negedge clk);
            tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL wrap_2: got %h expected 0", out_pc); end
            @(negedge clk);
            tests++; if (out_pc !== 32'h4) begin fails++; $display("FAIL wrap_3: got %h expected 4", out_pc); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1 out_ready = 0;
        repeat (3) @(negedge clk);
        tests++; if (dut.u_q.count !== 2'd2) begin fails++; $display("FAIL ar_full: got %0d expected 2", dut.u_q.count); end
`ifdef IFETCH_PERF_EN
        tests++; if (perf_fetched !== 32'(popped)) begin fails++; $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched, popped); end
        tests++; if (perf_flushes !== 16'd3) begin fails++; $display("FAIL perf_flushes: got %0d expected 3", perf_flushes); end
`endif
        @(posedge clk); #3 reset = 1; sb_on = 0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
        tests++; if (iaddr !== 32'h0) begin fails++; $display("FAIL ar_iaddr: got %h expected 0", iaddr); end
        tests++; if (out_instr !== NOP_INSTR || out_pc !== 32'h0) begin fails++; $display("FAIL ar_head: got %h/%h expected %h/0", out_instr, out_pc, NOP_INSTR); end
`ifdef IFETCH_PERF_EN
        tests++; if (perf_fetched !== 32'h0 || perf_flushes !== 16'h0) begin fails++; $display("FAIL ar_perf: got %0d/%0d expected 0/0", perf_fetched, perf_flushes); end
`endif
        repeat (2) @(posedge clk);
        #1 reset = 0; out_ready = 1; load_seq(32'h0); sb_on = 1;
        startup_checks();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_branch();
        test_branch_pop(32'h200, 1'b0);
        test_branch_pop(32'hFFFF_FFF8, 1'b1);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
